// File: rtl/spi_rom_stream_pkg.sv
// Shared constants for the SPI ROM stream feeder: address pages, status
// bit positions and small helper functions.
package spi_rom_stream_pkg;

    // Pages selected by spi_addr[31:24]
    localparam logic [7:0] PAGE_ROM  = 8'h00;
    localparam logic [7:0] PAGE_CTRL = 8'hFF;
    localparam logic [7:0] PAGE_CMD  = 8'hFE;

    // Bit positions inside the status byte
    localparam int ST_LOAD_DONE = 0;
    localparam int ST_DONE_REQ  = 1;
    localparam int ST_EMPTY     = 2;
    localparam int ST_FULL      = 3;
    localparam int ST_OVERFLOW  = 7;

    // Increment that sticks at 8'hFF instead of wrapping
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Assemble the status byte; unused bits read as zero
    function automatic logic [7:0] pack_status(input logic overflow,
                                               input logic full,
                                               input logic empty,
                                               input logic done_req,
                                               input logic load_done);
        logic [7:0] s;
        s               = 8'h00;
        s[ST_OVERFLOW]  = overflow;
        s[ST_FULL]      = full;
        s[ST_EMPTY]     = empty;
        s[ST_DONE_REQ]  = done_req;
        s[ST_LOAD_DONE] = load_done;
        return s;
    endfunction

endpackage

// File: rtl/spi_rom_stream_fifo.sv
// First-word-fall-through FIFO. The head entry is always presented on
// o_rdata; a push into a full FIFO is accepted only together with a pop.
module sync_fifo_fwft #(
    parameter int WIDTH      = 41,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);
    localparam int                  DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [WIDTH-1:0]      r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  w_pop_ok;
    logic                  w_push_ok;

    assign o_empty = (r_count == (DEPTH_LOG2 + 1)'(0));
    assign o_full  = (r_count == DEPTH_CNT);
    assign o_rdata = r_mem[r_rd_ptr];

    // Qualify push/pop: pop needs data, push into full needs a same-cycle pop
    always_comb begin
        w_pop_ok  = i_pop & ~o_empty;
        w_push_ok = i_push & (~o_full | w_pop_ok);
    end

    // Storage, pointers and occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {WIDTH{1'b0}};
            end
            r_wr_ptr <= DEPTH_LOG2'(0);
            r_rd_ptr <= DEPTH_LOG2'(0);
            r_count  <= (DEPTH_LOG2 + 1)'(0);
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= i_wdata;
                r_wr_ptr        <= r_wr_ptr + DEPTH_LOG2'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + (DEPTH_LOG2 + 1)'(1);
                2'b01:   r_count <= r_count - (DEPTH_LOG2 + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/spi_rom_stream.sv
// SPI write decoder for the ROM load path: pairs even/odd ROM bytes into
// 16-bit words queued for SDRAM, and owns the CPU-control register, the
// load-done command and a status byte.
module spi_rom_stream
    import spi_rom_stream_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4,
    parameter int ADDR_BITS  = 25
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 spi_wr,
    input  logic [31:0]          spi_addr,
    input  logic [7:0]           spi_data,
    output logic                 word_valid,
    input  logic                 word_ready,
    output logic [ADDR_BITS-1:0] word_addr,
    output logic [15:0]          word_data,
    output logic [7:0]           cpu_control,
    output logic                 load_done,
    output logic [7:0]           status,
    output logic [7:0]           drop_count
);
    localparam int FW = 16 + ADDR_BITS;

    logic          r_wr_q;
    logic [7:0]    r_lo;
    logic [7:0]    r_cpu_control;
    logic          r_done_req;
    logic          r_load_done;
    logic          r_overflow;
    logic [7:0]    r_drop_count;
    logic [7:0]    r_status;

    logic          w_stb;
    logic          w_lo_wr;
    logic          w_push_req;
    logic          w_ctrl_wr;
    logic          w_cmd_wr;
    logic          w_cmd_clr;
    logic          w_pop;
    logic          w_drop;
    logic          w_full;
    logic          w_empty;
    logic [FW-1:0] w_wdata;
    logic [FW-1:0] w_rdata;

    // One action per rising edge of the SPI write level
    assign w_stb = spi_wr & ~r_wr_q;

    // Page decode of the strobed write
    always_comb begin
        w_lo_wr    = 1'b0;
        w_push_req = 1'b0;
        w_ctrl_wr  = 1'b0;
        w_cmd_wr   = 1'b0;
        if (w_stb) begin
            case (spi_addr[31:24])
                PAGE_ROM: begin
                    if (spi_addr[0]) begin
                        w_push_req = 1'b1;
                    end else begin
                        w_lo_wr = 1'b1;
                    end
                end
                PAGE_CTRL: w_ctrl_wr = 1'b1;
                PAGE_CMD:  w_cmd_wr  = 1'b1;
                default:   w_lo_wr   = 1'b0;
            endcase
        end else begin
            w_lo_wr = 1'b0;
        end
    end

    // Odd byte completes the word; the even byte comes from the latch
    assign w_wdata   = {spi_addr[ADDR_BITS-1:1], 1'b0, spi_data, r_lo};
    assign w_cmd_clr = w_cmd_wr & ~spi_data[0];
    assign w_pop     = ~w_empty & word_ready;
    assign w_drop    = w_push_req & w_full & ~w_pop;

    sync_fifo_fwft #(
        .WIDTH      (FW),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push_req),
        .i_wdata (w_wdata),
        .i_pop   (w_pop),
        .o_rdata (w_rdata),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Edge register, byte latch, control/command registers and flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_q        <= 1'b0;
            r_lo          <= 8'h00;
            r_cpu_control <= 8'h00;
            r_done_req    <= 1'b0;
            r_load_done   <= 1'b0;
            r_overflow    <= 1'b0;
            r_drop_count  <= 8'h00;
            r_status      <= pack_status(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        end else begin
            r_wr_q <= spi_wr;
            if (w_lo_wr) begin
                r_lo <= spi_data;
            end
            if (w_ctrl_wr) begin
                r_cpu_control <= spi_data;
            end
            if (w_cmd_wr) begin
                r_done_req <= spi_data[0];
            end
            if (w_cmd_clr) begin
                r_overflow <= 1'b0;
            end else if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_drop) begin
                r_drop_count <= sat_inc8(r_drop_count);
            end
            // Done only once requested, drained, and nothing entering now
            if (w_cmd_clr) begin
                r_load_done <= 1'b0;
            end else if (r_done_req & w_empty & ~w_push_req) begin
                r_load_done <= 1'b1;
            end
            r_status <= pack_status(r_overflow, w_full, w_empty, r_done_req, r_load_done);
        end
    end

    assign word_valid  = ~w_empty;
    assign word_addr   = w_rdata[FW-1:16];
    assign word_data   = w_rdata[15:0];
    assign cpu_control = r_cpu_control;
    assign load_done   = r_load_done;
    assign status      = r_status;
    assign drop_count  = r_drop_count;

endmodule

// File: tb/tb_spi_rom_stream.sv
// Self-checking bench for spi_rom_stream: a queue-based reference model is
// stepped once per clock alongside the DUT, with table vectors, directed
// corner sequences and a randomized phase on top.
module tb_spi_rom_stream;
    localparam int DEPTH_LOG2 = 4;
    localparam int ADDR_BITS  = 25;
    localparam int DEPTH      = 1 << DEPTH_LOG2;

    logic        clk = 1'b0;
    logic        reset;
    logic        spi_wr;
    logic [31:0] spi_addr;
    logic [7:0]  spi_data;
    logic        word_valid;
    logic        word_ready;
    logic [24:0] word_addr;
    logic [15:0] word_data;
    logic [7:0]  cpu_control;
    logic        load_done;
    logic [7:0]  status;
    logic [7:0]  drop_count;

    spi_rom_stream #(.DEPTH_LOG2(DEPTH_LOG2), .ADDR_BITS(ADDR_BITS)) dut (
        .clk(clk), .reset(reset), .spi_wr(spi_wr), .spi_addr(spi_addr),
        .spi_data(spi_data), .word_valid(word_valid), .word_ready(word_ready),
        .word_addr(word_addr), .word_data(word_data), .cpu_control(cpu_control),
        .load_done(load_done), .status(status), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [40:0] mq[$];
    logic [7:0]  m_lo, m_cpu, m_drop, m_status;
    logic        m_wrq, m_done_req, m_ld, m_ovf;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_lo = 8'h00; m_cpu = 8'h00; m_drop = 8'h00; m_status = 8'h04;
        m_wrq = 1'b0; m_done_req = 1'b0; m_ld = 1'b0; m_ovf = 1'b0;
    endtask

    // Effect of one clock edge with the given inputs
    task automatic model_update(input logic wr, input logic [31:0] a, input logic [7:0] d, input logic rdy);
        logic stb, pop, push_try, clr, new_ld;
        int   sz;
        stb      = wr & ~m_wrq;
        m_wrq    = wr;
        sz       = mq.size();
        pop      = rdy && (sz > 0);
        push_try = stb && (a[31:24] == 8'h00) && a[0];
        clr      = stb && (a[31:24] == 8'hFE) && !d[0];
        new_ld   = clr ? 1'b0 : (m_ld | (m_done_req && (sz == 0) && !push_try));
        m_status = {m_ovf, 3'b000, (sz == DEPTH), (sz == 0), m_done_req, m_ld};
        if (pop) void'(mq.pop_front());
        if (stb) begin
            if (a[31:24] == 8'h00) begin
                if (!a[0]) m_lo = d;
                else if (sz < DEPTH || pop) mq.push_back({a[24:1], 1'b0, d, m_lo});
                else begin
                    m_ovf = 1'b1;
                    if (m_drop != 8'hFF) m_drop = m_drop + 8'd1;
                end
            end else if (a[31:24] == 8'hFF) m_cpu = d;
            else if (a[31:24] == 8'hFE) begin
                m_done_req = d[0];
                if (!d[0]) m_ovf = 1'b0;
            end
        end
        m_ld = new_ld;
    endtask

    task automatic compare_all();
        chk("word_valid", 64'(word_valid), 64'(mq.size() > 0));
        if (mq.size() > 0) begin
            chk("word_addr", 64'(word_addr), 64'(mq[0][40:16]));
            chk("word_data", 64'(word_data), 64'(mq[0][15:0]));
        end
        chk("cpu_control", 64'(cpu_control), 64'(m_cpu));
        chk("load_done",   64'(load_done),   64'(m_ld));
        chk("drop_count",  64'(drop_count),  64'(m_drop));
        chk("status",      64'(status),      64'(m_status));
    endtask

    // Drive inputs at a falling edge, let one rising edge act, compare at next falling edge
    task automatic step(input logic wr, input logic [31:0] a, input logic [7:0] d, input logic rdy);
        spi_wr = wr; spi_addr = a; spi_data = d; word_ready = rdy;
        model_update(wr, a, d, rdy);
        @(negedge clk);
        compare_all();
    endtask

    task automatic write_word(input logic [31:0] a, input logic [15:0] w, input logic rdy);
        step(1'b1, a,           w[7:0],  rdy);
        step(1'b0, a,           w[7:0],  rdy);
        step(1'b1, a | 32'h1,   w[15:8], rdy);
        step(1'b0, a | 32'h1,   w[15:8], rdy);
    endtask

    typedef struct {
        logic [31:0] a;
        logic [7:0]  d;
        logic        ev;
        logic [24:0] ea;
        logic [15:0] ed;
        logic [7:0]  ecpu;
    } vec_t;

    vec_t tbl[8];

    initial begin
        logic [7:0]  d0;
        logic [31:0] r32;
        int          sel;

        tbl[0] = '{32'h0000_0000, 8'h34, 1'b0, 25'h0,        16'h0,    8'h00};
        tbl[1] = '{32'h0000_0001, 8'h12, 1'b1, 25'h0,        16'h1234, 8'h00};
        tbl[2] = '{32'hFF00_0000, 8'h01, 1'b0, 25'h0,        16'h0,    8'h01};
        tbl[3] = '{32'h1200_0000, 8'h55, 1'b0, 25'h0,        16'h0,    8'h01};
        tbl[4] = '{32'h0000_0102, 8'hCD, 1'b0, 25'h0,        16'h0,    8'h01};
        tbl[5] = '{32'h0000_0103, 8'hAB, 1'b1, 25'h102,      16'hABCD, 8'h01};
        tbl[6] = '{32'h00FF_FFFE, 8'h77, 1'b0, 25'h0,        16'h0,    8'h01};
        tbl[7] = '{32'h00FF_FFFF, 8'h88, 1'b1, 25'hFF_FFFE,  16'h8877, 8'h01};

        reset = 1'b1; spi_wr = 1'b0; spi_addr = 32'h0; spi_data = 8'h0; word_ready = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_valid",  64'(word_valid),  64'(0));
        chk("rst_addr",   64'(word_addr),   64'(0));
        chk("rst_data",   64'(word_data),   64'(0));
        chk("rst_cpu",    64'(cpu_control), 64'(0));
        chk("rst_status", 64'(status),      64'(8'h04));
        chk("rst_drop",   64'(drop_count),  64'(0));

        // Table vectors: one write each, effect visible one cycle after the strobe
        for (int i = 0; i < 8; i++) begin
            step(1'b1, tbl[i].a, tbl[i].d, 1'b1);
            chk("tbl_valid", 64'(word_valid), 64'(tbl[i].ev));
            if (tbl[i].ev) begin
                chk("tbl_addr", 64'(word_addr), 64'(tbl[i].ea));
                chk("tbl_data", 64'(word_data), 64'(tbl[i].ed));
            end
            chk("tbl_cpu", 64'(cpu_control), 64'(tbl[i].ecpu));
            step(1'b0, tbl[i].a, tbl[i].d, 1'b1);
        end

        // spi_wr held high five cycles on an odd byte: exactly one push
        step(1'b1, 32'h200, 8'h11, 1'b0);
        step(1'b0, 32'h200, 8'h11, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 32'h201, 8'h22, 1'b0);
        chk("hold_one_word", 64'(word_valid), 64'(1));
        chk("hold_data", 64'(word_data), 64'(16'h2211));
        step(1'b0, 32'h0, 8'h0, 1'b1);
        chk("hold_single", 64'(word_valid), 64'(0));

        // Overflow: DEPTH+3 words with ready low
        for (int w = 0; w < DEPTH + 3; w++) write_word(32'(4 * w), {8'(w) ^ 8'hA5, 8'(w)}, 1'b0);
        chk("ovf_drop_count", 64'(drop_count), 64'(3));
        chk("ovf_flag", 64'(status[7]), 64'(1));
        chk("ovf_full", 64'(status[3]), 64'(1));
        for (int i = 0; i < DEPTH; i++) begin
            chk("ovf_order_addr", 64'(word_addr), 64'(4 * i));
            step(1'b0, 32'h0, 8'h0, 1'b1);
        end
        chk("ovf_drained", 64'(word_valid), 64'(0));

        // load_done after the last pop, survives new pushes, cleared by command
        for (int w = 0; w < 4; w++) write_word(32'h400 + 32'(2 * w), 16'h5000 + 16'(w), 1'b0);
        step(1'b1, 32'hFE00_0000, 8'h01, 1'b0);
        step(1'b0, 32'hFE00_0000, 8'h01, 1'b0);
        chk("ld_not_early", 64'(load_done), 64'(0));
        for (int k = 0; k < 30 && !load_done; k++) step(1'b0, 32'h0, 8'h0, 1'b1);
        chk("ld_rise", 64'(load_done), 64'(1));
        write_word(32'h500, 16'hBEEF, 1'b0);
        chk("ld_sticky", 64'(load_done), 64'(1));
        step(1'b0, 32'h0, 8'h0, 1'b1);
        step(1'b1, 32'hFE00_0000, 8'h00, 1'b1);
        step(1'b0, 32'hFE00_0000, 8'h00, 1'b1);
        chk("ld_clear", 64'(load_done), 64'(0));
        chk("ovf_clear", 64'(status[7]), 64'(0));

        // Full FIFO with simultaneous push and pop: no drop, stays full
        for (int w = 0; w < DEPTH; w++) write_word(32'h800 + 32'(2 * w), 16'(w * 3), 1'b0);
        d0 = m_drop;
        step(1'b1, 32'h900, 8'h66, 1'b0);
        step(1'b0, 32'h900, 8'h66, 1'b0);
        step(1'b1, 32'h901, 8'h99, 1'b1);
        step(1'b0, 32'h0,   8'h00, 1'b0);
        chk("pp_no_drop", 64'(drop_count), 64'(d0));
        chk("pp_full", 64'(status[3]), 64'(1));
        for (int i = 0; i < DEPTH; i++) step(1'b0, 32'h0, 8'h0, 1'b1);
        chk("pp_last", 64'(word_valid), 64'(0));

        // Randomized traffic against the model
        for (int c = 0; c < 800; c++) begin
            r32 = $urandom();
            sel = $urandom_range(0, 11);
            if (sel < 8)       r32 = {8'h00, 18'h0, r32[5:0]};
            else if (sel == 8) r32 = {8'hFF, r32[23:0]};
            else if (sel == 9) r32 = {8'hFE, r32[23:0]};
            else               r32 = {8'h5A, r32[23:0]};
            step(1'($urandom_range(0, 1)), r32, 8'($urandom()),
                 (c < 400) ? 1'($urandom_range(0, 3) == 0) : 1'($urandom_range(0, 3) != 0));
        end

        // Asynchronous reset in the middle of a burst
        for (int w = 0; w < 5; w++) write_word(32'h40 + 32'(2 * w), 16'hC0DE ^ 16'(w), 1'b0);
        step(1'b1, 32'hFF00_0000, 8'h5C, 1'b0);
        step(1'b1, 32'h0000_0010, 8'hEE, 1'b0);
        spi_wr = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("arst_valid",  64'(word_valid),  64'(0));
        chk("arst_addr",   64'(word_addr),   64'(0));
        chk("arst_data",   64'(word_data),   64'(0));
        chk("arst_cpu",    64'(cpu_control), 64'(0));
        chk("arst_ld",     64'(load_done),   64'(0));
        chk("arst_status", 64'(status),      64'(8'h04));
        chk("arst_drop",   64'(drop_count),  64'(0));
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        // Pending low byte was discarded: odd byte pairs with zero
        step(1'b1, 32'h0000_0021, 8'h3C, 1'b1);
        chk("arst_lo_cleared", 64'(word_data), 64'(16'h3C00));
        step(1'b0, 32'h0, 8'h0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time limit so the run always ends
    initial begin
        #2000000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "time limit");
    end

endmodule
